// File: rtl/uart_tx_sched.sv
// rtl/uart_tx_sched.sv - round-robin scheduler sharing one uart_tx between a byte source and a two-byte event source
// Each requester has a one-entry slot; requester-1 frames are header + code, sent atomically.
module uart_tx_sched #(
  parameter logic [7:0] EVT_HDR = 8'hA5,
  parameter int         BUSY_TO = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_code,
  output logic       req1_ready,
  input  logic       tx_busy,
  output logic [7:0] tx_data,
  output logic       tx_trigger,
  output logic       sched_busy,
  output logic       err_timeout
);

  typedef enum logic [1:0] {IDLE, TRIG, WAIT_BUSY, WAIT_DONE} state_t;

  localparam logic [7:0] CNT_LAST = 8'(BUSY_TO - 2);

  state_t     state;
  state_t     state_next;
  logic       slot0_full;
  logic       slot1_full;
  logic [7:0] slot0_data;
  logic [7:0] slot1_code;
  logic [7:0] shadow_code;
  logic       second_byte;
  logic       last_grant;
  logic [7:0] busy_cnt;
  logic       grant0;
  logic       grant1;
  logic       timeout;

  assign req0_ready = !slot0_full;
  assign req1_ready = !slot1_full;

  // last_grant=1 means requester 1 was served last, so requester 0 wins a tie.
  always_comb begin
    grant0  = (state == IDLE) && slot0_full && (!slot1_full || last_grant);
    grant1  = (state == IDLE) && slot1_full && (!slot0_full || !last_grant);
    timeout = (state == WAIT_BUSY) && !tx_busy && (busy_cnt == CNT_LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (grant0 || grant1) state_next = TRIG;
      TRIG:      state_next = WAIT_BUSY;
      WAIT_BUSY: begin
        if (tx_busy)      state_next = WAIT_DONE;
        else if (timeout) state_next = IDLE;
      end
      WAIT_DONE: if (!tx_busy) state_next = second_byte ? TRIG : IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_comb begin
    tx_trigger = (state == TRIG);
    sched_busy = (state != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot0_full  <= 1'b0;
      slot1_full  <= 1'b0;
      slot0_data  <= 8'h00;
      slot1_code  <= 8'h00;
      shadow_code <= 8'h00;
      second_byte <= 1'b0;
      last_grant  <= 1'b1;
      busy_cnt    <= 8'h00;
      tx_data     <= 8'h00;
      err_timeout <= 1'b0;
    end else begin
      if (req0_valid && !slot0_full) begin
        slot0_full <= 1'b1;
        slot0_data <= req0_data;
      end else if (grant0) begin
        slot0_full <= 1'b0;
      end
      if (req1_valid && !slot1_full) begin
        slot1_full <= 1'b1;
        slot1_code <= req1_code;
      end else if (grant1) begin
        slot1_full <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (grant0) begin
            tx_data    <= slot0_data;
            last_grant <= 1'b0;
          end else if (grant1) begin
            tx_data     <= EVT_HDR;
            shadow_code <= slot1_code;
            second_byte <= 1'b1;
            last_grant  <= 1'b1;
          end
        end
        TRIG: busy_cnt <= 8'h00;
        WAIT_BUSY: begin
          if (!tx_busy) begin
            if (timeout) begin
              err_timeout <= 1'b1;
              second_byte <= 1'b0;
            end else begin
              busy_cnt <= busy_cnt + 8'h01;
            end
          end
        end
        WAIT_DONE: begin
          if (!tx_busy && second_byte) begin
            tx_data     <= shadow_code;
            second_byte <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
